// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the LC-3b MEM-stage sequencer.
// Holds the FSM state enum and the mem_byte_sig encodings.
package mem_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC1,
    ST_PTR,
    ST_ACC2,
    ST_DONE
  } mem_ctrl_state_e;

  localparam logic [1:0] MEM_BSIG_BYTE = 2'b01;
  localparam logic [1:0] MEM_BSIG_WORD = 2'b11;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Single-port data-memory bus between the MEM stage and dmem.
// master = MEM-stage sequencer, slave = memory.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [1:0]        dmem_be;
  logic              dmem_resp;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_resp,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_resp,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_byte_align.sv
// Byte-lane steering for 16-bit data memory.
// Any bsig other than byte is treated as a word access.
module mem_byte_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic        addr0,
  input  logic [1:0]  bsig,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  be,
  output logic [15:0] wdata_out,
  output logic [15:0] rdata_out
);

  always_comb begin
    be        = 2'b11;
    wdata_out = wdata;
    rdata_out = rdata;
    if (bsig == MEM_BSIG_BYTE) begin
      be        = addr0 ? 2'b10 : 2'b01;
      wdata_out = {wdata[7:0], wdata[7:0]};
      rdata_out = {8'h00, addr0 ? rdata[15:8] : rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer: dmem handshake, LDI/STI pointer
// chasing, byte alignment, stall generation and a response watchdog.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_ind,
  input  logic [1:0]        mem_bsig,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  mem_stage_ctrl_if.master  dbus,
  output logic              stall_mem,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);

  mem_ctrl_state_e   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ind_q, ind_d;
  logic [1:0]        bsig_q, bsig_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic              req;
  logic              acc;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_bsig;
  logic [1:0]        be_al;
  logic [DATA_W-1:0] wdata_al;
  logic [DATA_W-1:0] rdata_al;

  assign req = mem_valid & (mem_read | mem_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ind_q   <= 1'b0;
      bsig_q  <= 2'b00;
      ptr_q   <= '0;
      ldata_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ind_q   <= ind_d;
      bsig_q  <= bsig_d;
      ptr_q   <= ptr_d;
      ldata_q <= ldata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Access decode only; kept apart from next-state so the aligner
  // feedback into ldata_d does not form a block-level loop.
  always_comb begin
    acc       = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_bsig  = MEM_BSIG_WORD;
    stall_mem = 1'b0;
    unique case (state_q)
      ST_IDLE: stall_mem = req;
      ST_ACC1: begin
        stall_mem = 1'b1;
        acc       = 1'b1;
        acc_addr  = addr_q;
        if (ind_q) begin
          acc_rd = 1'b1;
        end else begin
          acc_rd   = rd_q;
          acc_wr   = wr_q;
          acc_bsig = bsig_q;
        end
      end
      ST_PTR: stall_mem = 1'b1;
      ST_ACC2: begin
        stall_mem = 1'b1;
        acc       = 1'b1;
        acc_addr  = ptr_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
      end
      ST_DONE: stall_mem = 1'b0;
      default: stall_mem = 1'b0;
    endcase
  end

  mem_byte_align u_align (
    .addr0     (acc_addr[0]),
    .bsig      (acc_bsig),
    .wdata     (wdata_q),
    .rdata     (dbus.dmem_rdata),
    .be        (be_al),
    .wdata_out (wdata_al),
    .rdata_out (rdata_al)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ind_d   = ind_q;
    bsig_d  = bsig_q;
    ptr_d   = ptr_q;
    ldata_d = ldata_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wr_d    = mem_write;
          rd_d    = mem_read & ~mem_write;
          ind_d   = mem_ind;
          bsig_d  = mem_bsig;
          wait_d  = '0;
          state_d = ST_ACC1;
        end
      end
      ST_ACC1, ST_ACC2: begin
        if (dbus.dmem_resp) begin
          wait_d = '0;
          if (state_q == ST_ACC1 && ind_q) begin
            ptr_d   = dbus.dmem_rdata;
            state_d = ST_PTR;
          end else begin
            ldata_d = rd_q ? rdata_al : '0;
            state_d = ST_DONE;
          end
        end else if (wait_q == WAIT_LIM) begin
          err_d   = 1'b1;
          ldata_d = '0;
          wait_d  = '0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_PTR: begin
        wait_d  = '0;
        state_d = ST_ACC2;
      end
      ST_DONE: begin
        wait_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dbus.dmem_read  = acc_rd;
    dbus.dmem_write = acc_wr;
    dbus.dmem_be    = acc ? be_al : 2'b00;
    dbus.dmem_wdata = acc_wr ? wdata_al : '0;
    dbus.dmem_addr  = '0;
    if (acc) begin
      dbus.dmem_addr = (acc_bsig == MEM_BSIG_BYTE) ? acc_addr
                       : {acc_addr[ADDR_W-1:1], 1'b0};
    end
  end

  assign load_data = ldata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (MAX_WAIT=8).
// One task per scenario, inline checks against hand-computed values.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_ind = 1'b0;
  logic [1:0]  mem_bsig = 2'b11;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        stall_mem;
  logic [15:0] load_data;
  logic        mem_err;

  int checks = 0;
  int fails = 0;
  int sc;

  mem_stage_ctrl_if #(.ADDR_W(16), .DATA_W(16)) dbus ();

  mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ind   (mem_ind),
    .mem_bsig  (mem_bsig),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .dbus      (dbus),
    .stall_mem (stall_mem),
    .load_data (load_data),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic ind,
                       input logic [1:0] bs, input logic [15:0] a,
                       input logic [15:0] wd);
    mem_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    mem_ind   = ind;
    mem_bsig  = bs;
    mem_addr  = a;
    mem_wdata = wd;
    #1;
  endtask

  task automatic drop_req;
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ind   = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dbus.dmem_resp = 1'b0;
    dbus.dmem_rdata = '0;
    step();
    step();
    checks++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", stall_mem); end
    checks++; if (dbus.dmem_read !== 1'b0 || dbus.dmem_write !== 1'b0) begin fails++; $display("FAIL rst_strobe got r=%b w=%b exp 0", dbus.dmem_read, dbus.dmem_write); end
    checks++; if (load_data !== 16'h0) begin fails++; $display("FAIL rst_ldata got %h exp 0000", load_data); end
    checks++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", mem_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ldr;
    sc = 0;
    issue(1'b1, 1'b0, 1'b0, 2'b11, 16'h1005, 16'h0);
    checks++; if (stall_mem !== 1'b1 || dbus.dmem_read !== 1'b0) begin fails++; $display("FAIL ldr_idle got stall=%b rd=%b exp 1 0", stall_mem, dbus.dmem_read); end
    sc += int'(stall_mem);
    step();
    drop_req();
    checks++; if (dbus.dmem_read !== 1'b1 || dbus.dmem_addr !== 16'h1004 || dbus.dmem_be !== 2'b11) begin fails++; $display("FAIL ldr_acc got rd=%b a=%h be=%b exp 1 1004 11", dbus.dmem_read, dbus.dmem_addr, dbus.dmem_be); end
    sc += int'(stall_mem);
    dbus.dmem_resp = 1'b1;
    dbus.dmem_rdata = 16'hBEEF;
    step();
    dbus.dmem_resp = 1'b0;
    sc += int'(stall_mem);
    checks++; if (load_data !== 16'hBEEF || dbus.dmem_read !== 1'b0) begin fails++; $display("FAIL ldr_done got ld=%h rd=%b exp beef 0", load_data, dbus.dmem_read); end
    checks++; if (sc !== 2) begin fails++; $display("FAIL ldr_stall_cycles got %0d exp 2", sc); end
    step();
    checks++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL ldr_idle_after got %b exp 0", stall_mem); end
  endtask

  task automatic test_ldb;
    issue(1'b1, 1'b0, 1'b0, 2'b01, 16'h2001, 16'h0);
    step();
    drop_req();
    checks++; if (dbus.dmem_addr !== 16'h2001 || dbus.dmem_be !== 2'b10 || dbus.dmem_read !== 1'b1) begin fails++; $display("FAIL ldb_acc got a=%h be=%b rd=%b exp 2001 10 1", dbus.dmem_addr, dbus.dmem_be, dbus.dmem_read); end
    dbus.dmem_rdata = 16'h12AB;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (stall_mem !== 1'b1 || dbus.dmem_read !== 1'b1) begin fails++; $display("FAIL ldb_wait%0d got stall=%b rd=%b exp 1 1", i, stall_mem, dbus.dmem_read); end
    end
    dbus.dmem_resp = 1'b1;
    step();
    dbus.dmem_resp = 1'b0;
    checks++; if (load_data !== 16'h0012 || stall_mem !== 1'b0) begin fails++; $display("FAIL ldb_done got ld=%h stall=%b exp 0012 0", load_data, stall_mem); end
    step();
  endtask

  task automatic test_stb;
    issue(1'b0, 1'b1, 1'b0, 2'b01, 16'h2000, 16'h00C3);
    step();
    drop_req();
    checks++; if (dbus.dmem_write !== 1'b1 || dbus.dmem_read !== 1'b0) begin fails++; $display("FAIL stb_strobe got w=%b r=%b exp 1 0", dbus.dmem_write, dbus.dmem_read); end
    checks++; if (dbus.dmem_be !== 2'b01 || dbus.dmem_wdata !== 16'hC3C3 || dbus.dmem_addr !== 16'h2000) begin fails++; $display("FAIL stb_lane got be=%b wd=%h a=%h exp 01 c3c3 2000", dbus.dmem_be, dbus.dmem_wdata, dbus.dmem_addr); end
    dbus.dmem_resp = 1'b1;
    step();
    dbus.dmem_resp = 1'b0;
    checks++; if (stall_mem !== 1'b0 || dbus.dmem_write !== 1'b0) begin fails++; $display("FAIL stb_done got stall=%b w=%b exp 0 0", stall_mem, dbus.dmem_write); end
    step();
  endtask

  task automatic test_ldi;
    sc = 0;
    issue(1'b1, 1'b0, 1'b1, 2'b01, 16'h3000, 16'h0);
    sc += int'(stall_mem);
    step();
    drop_req();
    sc += int'(stall_mem);
    checks++; if (dbus.dmem_read !== 1'b1 || dbus.dmem_addr !== 16'h3000 || dbus.dmem_be !== 2'b11) begin fails++; $display("FAIL ldi_acc1 got rd=%b a=%h be=%b exp 1 3000 11", dbus.dmem_read, dbus.dmem_addr, dbus.dmem_be); end
    dbus.dmem_resp = 1'b1;
    dbus.dmem_rdata = 16'h4002;
    step();
    sc += int'(stall_mem);
    checks++; if (dbus.dmem_read !== 1'b0 || stall_mem !== 1'b1) begin fails++; $display("FAIL ldi_ptr got rd=%b stall=%b exp 0 1", dbus.dmem_read, stall_mem); end
    dbus.dmem_rdata = 16'h0000;
    step();
    sc += int'(stall_mem);
    checks++; if (dbus.dmem_read !== 1'b1 || dbus.dmem_addr !== 16'h4002 || dbus.dmem_be !== 2'b11) begin fails++; $display("FAIL ldi_acc2 got rd=%b a=%h be=%b exp 1 4002 11", dbus.dmem_read, dbus.dmem_addr, dbus.dmem_be); end
    dbus.dmem_rdata = 16'h5555;
    step();
    dbus.dmem_resp = 1'b0;
    sc += int'(stall_mem);
    checks++; if (load_data !== 16'h5555) begin fails++; $display("FAIL ldi_data got %h exp 5555", load_data); end
    checks++; if (sc !== 4) begin fails++; $display("FAIL ldi_stall_cycles got %0d exp 4", sc); end
    step();
  endtask

  task automatic test_sti_timeout;
    issue(1'b0, 1'b1, 1'b1, 2'b11, 16'h3000, 16'h1234);
    step();
    drop_req();
    for (int i = 0; i < 8; i++) begin
      checks++; if (dbus.dmem_read !== 1'b1 || mem_err !== 1'b0) begin fails++; $display("FAIL sti_wait%0d got rd=%b err=%b exp 1 0", i, dbus.dmem_read, mem_err); end
      step();
    end
    checks++; if (mem_err !== 1'b1 || dbus.dmem_read !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL sti_abort got err=%b rd=%b stall=%b exp 1 0 0", mem_err, dbus.dmem_read, stall_mem); end
    checks++; if (load_data !== 16'h0) begin fails++; $display("FAIL sti_ldata got %h exp 0000", load_data); end
    step();
    checks++; if (mem_err !== 1'b1 || stall_mem !== 1'b0 || dbus.dmem_write !== 1'b0) begin fails++; $display("FAIL sti_sticky got err=%b stall=%b w=%b exp 1 0 0", mem_err, stall_mem, dbus.dmem_write); end
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0);
    step();
    drop_req();
    dbus.dmem_resp = 1'b1;
    dbus.dmem_rdata = 16'h4444;
    step();
    dbus.dmem_resp = 1'b0;
    step();
    checks++; if (dbus.dmem_read !== 1'b1 || dbus.dmem_addr !== 16'h4444) begin fails++; $display("FAIL rmid_acc2 got rd=%b a=%h exp 1 4444", dbus.dmem_read, dbus.dmem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (dbus.dmem_read !== 1'b0 || stall_mem !== 1'b0 || mem_err !== 1'b0) begin fails++; $display("FAIL rmid_async got rd=%b stall=%b err=%b exp 0 0 0", dbus.dmem_read, stall_mem, mem_err); end
    step();
    rst_n = 1'b1;
    dbus.dmem_resp = 1'b1;
    dbus.dmem_rdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (stall_mem !== 1'b0 || dbus.dmem_read !== 1'b0 || load_data !== 16'h0) begin fails++; $display("FAIL spur%0d got stall=%b rd=%b ld=%h exp 0 0 0000", i, stall_mem, dbus.dmem_read, load_data); end
    end
    dbus.dmem_resp = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 2'b11, 16'h0042, 16'hA5A5);
    step();
    drop_req();
    checks++; if (dbus.dmem_write !== 1'b1 || dbus.dmem_read !== 1'b0 || dbus.dmem_wdata !== 16'hA5A5) begin fails++; $display("FAIL rw_write_wins got w=%b r=%b wd=%h exp 1 0 a5a5", dbus.dmem_write, dbus.dmem_read, dbus.dmem_wdata); end
    dbus.dmem_resp = 1'b1;
    step();
    dbus.dmem_resp = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_ldb();
    test_stb();
    test_ldi();
    test_sti_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
